// File: rtl/br_pkg.sv
// Shared constants for the branch controller: opcode fields, B.cond codes,
// flag bit positions and the stall FSM state type.
package br_pkg;

  // Opcode fields (B/BL use instr[31:26]; CBZ/B.cond use instr[31:24])
  localparam logic [5:0] OP_B     = 6'b000101;
  localparam logic [5:0] OP_BL    = 6'b100101;
  localparam logic [7:0] OP_CBZ   = 8'b10110100;
  localparam logic [7:0] OP_BCOND = 8'b01010100;

  // Supported B.cond condition codes; anything else is never taken
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;

  // Bit positions inside the {N,Z,V,C} flag vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [0:0] {
    IDLE,
    WAIT_FLAGS
  } br_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational B.cond evaluator: condition code plus {N,Z,V,C} -> taken.
module cond_eval
  import br_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_taken
);

  logic w_n, w_z, w_v;
  logic w_unused_c;

  assign w_n        = i_flags[FLAG_N];
  assign w_z        = i_flags[FLAG_Z];
  assign w_v        = i_flags[FLAG_V];
  // Carry is part of the flag register but no supported condition reads it
  assign w_unused_c = i_flags[FLAG_C];

  // Decode the condition code against the flags
  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_EQ: o_taken = w_z;
      COND_NE: o_taken = ~w_z;
      COND_GE: o_taken = (w_n == w_v);
      COND_LT: o_taken = (w_n != w_v);
      COND_GT: o_taken = ~w_z && (w_n == w_v);
      COND_LE: o_taken = w_z || (w_n != w_v);
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller for the RF stage: decodes B, BL, CBZ and B.cond, keeps the
// {N,Z,V,C} flag register, and stalls one cycle when a B.cond meets a
// flag-setting instruction in EX. Optional statistics counters are enabled
// by defining BR_STATS_EN.
module branch_ctrl
  import br_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        flag_wr_ex,
  input  logic        alu_neg,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  input  logic        alu_cout,
  input  logic        rt_zero,
  output logic        BrTaken,
  output logic        UncondBr,
  output logic [18:0] Imm19,
  output logic [25:0] Imm26,
  output logic        link_wr,
`ifdef BR_STATS_EN
  output logic        stall,
  output logic [31:0] br_count,
  output logic [31:0] taken_count
`else
  output logic        stall
`endif
);

  logic [3:0] r_flags;
  br_state_e  r_state;
  br_state_e  w_state_next;

  logic w_is_b, w_is_bl, w_is_cbz, w_is_bcond;
  logic w_cond_taken;
  logic w_br_taken, w_uncond, w_link, w_stall;

  assign w_is_b     = (instr[31:26] == OP_B);
  assign w_is_bl    = (instr[31:26] == OP_BL);
  assign w_is_cbz   = (instr[31:24] == OP_CBZ);
  assign w_is_bcond = (instr[31:24] == OP_BCOND);

  assign Imm19 = instr[23:5];
  assign Imm26 = instr[25:0];

  cond_eval u_cond_eval (
    .i_cond  (instr[3:0]),
    .i_flags (r_flags),
    .o_taken (w_cond_taken)
  );

  // Flag register: load from the EX-stage ALU whenever EX sets flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else if (flag_wr_ex) begin
      r_flags <= {alu_neg, alu_zero, alu_ovf, alu_cout};
    end
  end

  // Stall FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Decode and next state; WAIT_FLAGS always falls back to IDLE so a stall
  // can never last two cycles
  always_comb begin
    w_state_next = IDLE;
    w_br_taken   = 1'b0;
    w_uncond     = 1'b0;
    w_link       = 1'b0;
    w_stall      = 1'b0;
    if (reset) begin
      if (w_is_b) begin
        w_uncond   = 1'b1;
        w_br_taken = 1'b1;
      end else if (w_is_bl) begin
        w_uncond   = 1'b1;
        w_br_taken = 1'b1;
        w_link     = 1'b1;
      end else if (w_is_cbz) begin
        w_br_taken = rt_zero;
      end else if (w_is_bcond) begin
        if ((r_state == IDLE) && flag_wr_ex) begin
          // Flags change this edge: hold the branch and resolve next cycle
          w_stall      = 1'b1;
          w_state_next = WAIT_FLAGS;
        end else begin
          w_br_taken = w_cond_taken;
        end
      end
    end
  end

  assign BrTaken  = w_br_taken;
  assign UncondBr = w_uncond;
  assign link_wr  = w_link;
  assign stall    = w_stall;

`ifdef BR_STATS_EN
  logic [31:0] r_br_count;
  logic [31:0] r_taken_count;
  logic        w_resolved;

  assign w_resolved = (w_is_b | w_is_bl | w_is_cbz | w_is_bcond) & ~w_stall & reset;

  // Count resolved branches and taken ones; both wrap naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_br_count    <= 32'd0;
      r_taken_count <= 32'd0;
    end else if (w_resolved) begin
      r_br_count <= r_br_count + 32'd1;
      if (w_br_taken) begin
        r_taken_count <= r_taken_count + 32'd1;
      end
    end
  end

  assign br_count    = r_br_count;
  assign taken_count = r_taken_count;
`endif

endmodule
